difftest_lr_sc_event_queue: RTL and testbench
=============================================

DIFFTEST_LR_SC_EVENT_QUEUE -- requirements
Module: difftest_lr_sc_event_queue

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent LR/SC event channels (1..8).
REQ-002 SHALL have parameter DEPTH, default 4, entries per channel FIFO (power of two, 2..16).
REQ-003 SHALL have parameter CNT_W, default 32, width of statistics counters.
REQ-004 clock  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 enable  input  1  global capture enable; events ignored when 0.
REQ-007 io_valid  input  NUM_CH  per-channel LR/SC event strobe.
REQ-008 io_success  input  NUM_CH  per-channel SC success flag.
REQ-009 io_coreid  input  8*NUM_CH  per-channel core id, channel i in bits [8i+7:8i].
REQ-010 out_valid  output  1  an event is presented.
REQ-011 out_ready  input  1  consumer accepts presented event.
REQ-012 out_success  output  1  success flag of presented event.
REQ-013 out_coreid  output  8  core id of presented event.
REQ-014 out_channel  output  3  source channel index of presented event.
REQ-015 overflow  output  NUM_CH  sticky per-channel event-dropped flag.
REQ-016 sc_ok_cnt, sc_fail_cnt  output  CNT_W  counts of delivered successful / failed SC events.

Function
REQ-017 Channel i SHALL enqueue {io_success[i], io_coreid[i]} at a rising edge where enable=1 and io_valid[i]=1 and its FIFO is not full or is being popped that same cycle.
REQ-018 All channels SHALL enqueue concurrently, with no cross-channel back-pressure.
REQ-019 An event enqueued at edge N SHALL be presentable no earlier than cycle N+1 (no combinational bypass).
REQ-020 out_valid SHALL be 1 whenever any FIFO is non-empty; out_* SHALL be driven from the selected FIFO head.
REQ-021 Selection SHALL be round-robin: the non-empty channel at or after rr_ptr in index order wins.
REQ-022 Once out_valid=1 with out_ready=0, the selection and all out_* SHALL be held stable until handshake.
REQ-023 A handshake (out_valid & out_ready) SHALL pop the granted FIFO and set rr_ptr to granted+1 modulo NUM_CH; rr_ptr SHALL not change otherwise.
REQ-024 On handshake, sc_ok_cnt SHALL increment if out_success=1, else sc_fail_cnt SHALL increment; both counters saturate at all-ones.
REQ-025 An enqueue attempt on a full FIFO not popped that cycle SHALL drop the event and set overflow[i]=1 until reset.
REQ-026 Simultaneous push and pop on the same FIFO SHALL keep occupancy unchanged and preserve FIFO order.
REQ-027 FIFO pointers SHALL be log2(DEPTH)+1 bits wide, wrapping naturally; full = same index with differing MSB.
REQ-028 Per-channel event order SHALL be preserved end to end; no ordering is guaranteed across channels.

Reset
REQ-029 Asserting reset (0) SHALL immediately clear all FIFOs, rr_ptr=0, overflow=0, both counters=0, out_valid=0.
REQ-030 Reset mid-operation SHALL discard all queued events; no event captured before deassertion SHALL appear afterwards.
REQ-031 The first enqueue SHALL occur at the first rising edge after reset deassertion.

Structure
REQ-032 A shared difftest package SHALL hold the lrsc_entry typedef {success, coreid[7:0]} and the COREID_W=8 constant.
REQ-033 The per-channel buffer SHALL be one sub-module, difftest_event_fifo, instantiated NUM_CH times.
REQ-034 Arbiter, counters and overflow flags SHALL reside in the top module.

Verification
REQ-035 Single event: ch0 valid, success=1, coreid=0x03 at edge 1, out_ready=1 -> out_valid=1 in cycle 2 with coreid 0x03, channel 0; sc_ok_cnt=1 at edge 2.
REQ-036 Fairness: both channels push 3 events each on edges 1-3, out_ready=1 -> output channel sequence 0,1,0,1,0,1.
REQ-037 Overflow: DEPTH=4, out_ready=0, ch1 pushes 5 events -> first 4 retained, overflow=2'b10; releasing out_ready delivers exactly 4 events.
REQ-038 Stall: out_ready=0 for 5 cycles with ch0 head coreid=0x11 and ch1 pushing -> out_* constant 0x11/ch0 for all 5 cycles.
REQ-039 Full push-pop: ch0 full, out_ready=1, push coreid=0x22 -> no overflow, occupancy stays 4, 0x22 delivered last.
REQ-040 Reset mid-run: 3 queued events, reset low for one cycle -> out_valid=0 and counters=0 immediately; no stale event after release.

Source files
------------

// File: rtl/difftest_lr_sc_event_queue_pkg.sv
// Shared types and constants for the LR/SC difftest event queue.
//   lrsc_entry : one captured event {success, coreid}
//   COREID_W   : width of a core id
//   CH_IDX_W   : width of a channel index on the output side
package difftest_lr_sc_event_queue_pkg;

    localparam int COREID_W = 8;
    localparam int CH_IDX_W = 3;

    typedef struct packed {
        logic                success;
        logic [COREID_W-1:0] coreid;
    } lrsc_entry;

endpackage

// File: rtl/difftest_lr_sc_event_queue_if.sv
// Output event stream of the LR/SC event queue (valid/ready handshake).
//   out_valid   : an event is presented
//   out_ready   : consumer accepts the presented event
//   out_success : SC success flag of the presented event
//   out_coreid  : core id of the presented event
//   out_channel : source channel of the presented event
interface difftest_lr_sc_event_queue_if;
    import difftest_lr_sc_event_queue_pkg::*;

    logic                out_valid;
    logic                out_ready;
    logic                out_success;
    logic [COREID_W-1:0] out_coreid;
    logic [CH_IDX_W-1:0] out_channel;

    modport master (
        output out_valid,
        output out_success,
        output out_coreid,
        output out_channel,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_success,
        input  out_coreid,
        input  out_channel,
        output out_ready
    );

endinterface

// File: rtl/difftest_event_fifo.sv
// Per-channel event FIFO.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   push         : write push_data (caller guarantees room or a same-cycle pop)
//   pop          : drop the head entry (caller guarantees non-empty)
//   head         : current head entry, read from registered storage only
//   empty, full  : occupancy flags derived from the pointers
module difftest_event_fifo
    import difftest_lr_sc_event_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  lrsc_entry push_data,
    input  logic      pop,
    output lrsc_entry head,
    output logic      empty,
    output logic      full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    lrsc_entry   mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage holds data only, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/difftest_lr_sc_event_queue.sv
// LR/SC event queue: NUM_CH independent channels capture {success, coreid}
// events into private FIFOs; a round-robin arbiter merges them onto one
// valid/ready output stream and tallies delivered SC outcomes.
//   clock, reset           : rising-edge clock, asynchronous active-low reset
//   enable                 : global capture enable
//   io_valid/io_success    : per-channel event strobe and SC result
//   io_coreid              : per-channel core id, channel i in [8i+7:8i]
//   out_if (master)        : merged output stream
//   overflow               : sticky per-channel dropped-event flag
//   sc_ok_cnt/sc_fail_cnt  : saturating counts of delivered SC outcomes
module difftest_lr_sc_event_queue
    import difftest_lr_sc_event_queue_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_CH-1:0]            io_valid,
    input  logic [NUM_CH-1:0]            io_success,
    input  logic [COREID_W*NUM_CH-1:0]   io_coreid,
    difftest_lr_sc_event_queue_if.master out_if,
    output logic [NUM_CH-1:0]            overflow,
    output logic [CNT_W-1:0]             sc_ok_cnt,
    output logic [CNT_W-1:0]             sc_fail_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [NUM_CH-1:0]   empty;
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   push;
    logic [NUM_CH-1:0]   pop;
    logic [NUM_CH-1:0]   drop;
    lrsc_entry           head [NUM_CH];

    logic [CH_IDX_W-1:0] rr_ptr;
    logic [CH_IDX_W-1:0] rr_ch;
    logic                rr_found;
    logic                hold_vld;
    logic [CH_IDX_W-1:0] hold_ch;
    logic [CH_IDX_W-1:0] grant;
    lrsc_entry           sel;
    logic                handshake;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        lrsc_entry in_entry;
        logic      attempt;

        assign in_entry = {io_success[i], io_coreid[COREID_W*i +: COREID_W]};
        assign attempt  = enable & io_valid[i];
        // A full FIFO still accepts when its head leaves in the same cycle.
        assign push[i]  = attempt & (~full[i] | pop[i]);
        assign drop[i]  = attempt & full[i] & ~pop[i];
        assign pop[i]   = handshake & (grant == CH_IDX_W'(i));

        difftest_event_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push[i]),
            .push_data (in_entry),
            .pop       (pop[i]),
            .head      (head[i]),
            .empty     (empty[i]),
            .full      (full[i])
        );
    end

    // First non-empty channel at or after rr_ptr, wrapping to the low indices.
    always_comb begin
        rr_found = 1'b0;
        rr_ch    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rr_found && !empty[c] && (c >= int'(rr_ptr))) begin
                rr_found = 1'b1;
                rr_ch    = CH_IDX_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rr_found && !empty[c]) begin
                rr_found = 1'b1;
                rr_ch    = CH_IDX_W'(c);
            end
        end
    end

    // A stalled presentation is locked: a late push to a higher-priority
    // channel must not swap the event the consumer is already looking at.
    assign grant = hold_vld ? hold_ch : rr_ch;

    always_comb begin
        sel = head[0];
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant == CH_IDX_W'(c)) sel = head[c];
        end
    end

    assign out_if.out_valid   = |(~empty);
    assign out_if.out_success = sel.success;
    assign out_if.out_coreid  = sel.coreid;
    assign out_if.out_channel = grant;
    assign handshake          = out_if.out_valid & out_if.out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            hold_vld    <= 1'b0;
            hold_ch     <= '0;
            overflow    <= '0;
            sc_ok_cnt   <= '0;
            sc_fail_cnt <= '0;
        end else begin
            hold_vld <= out_if.out_valid & ~out_if.out_ready;
            hold_ch  <= grant;
            overflow <= overflow | drop;
            if (handshake) begin
                rr_ptr <= (grant == CH_IDX_W'(NUM_CH - 1)) ? '0 : grant + CH_IDX_W'(1);
                if (sel.success) sc_ok_cnt   <= sat_inc(sc_ok_cnt);
                else             sc_fail_cnt <= sat_inc(sc_fail_cnt);
            end
        end
    end

endmodule

// File: tb/tb_difftest_lr_sc_event_queue.sv
// Directed bench for the LR/SC event queue (NUM_CH=2, DEPTH=4, CNT_W=32).
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// later, i.e. they show the state left by the previous rising edge.
module tb_difftest_lr_sc_event_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  io_valid;
    logic [1:0]  io_success;
    logic [15:0] io_coreid;
    logic [1:0]  overflow;
    logic [31:0] sc_ok_cnt;
    logic [31:0] sc_fail_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    difftest_lr_sc_event_queue_if ifc ();

    difftest_lr_sc_event_queue #(.NUM_CH(2), .DEPTH(4), .CNT_W(32)) dut (
        .clock       (clk),
        .reset       (rst_n),
        .enable      (enable),
        .io_valid    (io_valid),
        .io_success  (io_success),
        .io_coreid   (io_coreid),
        .out_if      (ifc),
        .overflow    (overflow),
        .sc_ok_cnt   (sc_ok_cnt),
        .sc_fail_cnt (sc_fail_cnt)
    );

    typedef struct {
        logic        do_rst;
        logic        en;
        logic [1:0]  vld;
        logic [1:0]  suc;
        logic [15:0] cid;
        logic        rdy;
        logic        e_vld;
        logic        e_suc;
        logic [7:0]  e_cid;
        logic [2:0]  e_ch;
        logic [1:0]  e_ovf;
        logic [31:0] e_ok;
        logic [31:0] e_fail;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] vld, input logic [1:0] suc,
                         input logic [15:0] cid, input logic rdy);
        enable        = en;
        io_valid      = vld;
        io_success    = suc;
        io_coreid     = cid;
        ifc.out_ready = rdy;
    endtask

    // Called on a falling edge; returns on the falling edge that releases reset.
    task automatic do_reset();
        drive(1'b0, 2'b00, 2'b00, 16'h0000, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called on a falling edge; accepts whatever is presented for max_cyc cycles.
    task automatic drain(input int max_cyc);
        got_q.delete();
        drive(1'b0, 2'b00, 2'b00, 16'h0000, 1'b1);
        for (int c = 0; c < max_cyc; c++) begin
            #1;
            if (ifc.out_valid === 1'b1) got_q.push_back(ifc.out_coreid);
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] got_at(input int j);
        return (j < got_q.size()) ? got_q[j] : 8'hxx;
    endfunction

    initial begin
        // single event, then fairness from a fresh reset
        tbl[0]  = '{1'b1, 1'b1, 2'b01, 2'b01, 16'h0003, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 2'b00, 32'd0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h03, 3'd0, 2'b00, 32'd0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 2'b00, 32'd1, 32'd0};
        tbl[3]  = '{1'b1, 1'b1, 2'b11, 2'b01, 16'h2010, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 2'b00, 32'd0, 32'd0};
        tbl[4]  = '{1'b0, 1'b1, 2'b11, 2'b01, 16'h2111, 1'b1, 1'b1, 1'b1, 8'h10, 3'd0, 2'b00, 32'd0, 32'd0};
        tbl[5]  = '{1'b0, 1'b1, 2'b11, 2'b01, 16'h2212, 1'b1, 1'b1, 1'b0, 8'h20, 3'd1, 2'b00, 32'd1, 32'd0};
        tbl[6]  = '{1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h11, 3'd0, 2'b00, 32'd1, 32'd1};
        tbl[7]  = '{1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h21, 3'd1, 2'b00, 32'd2, 32'd1};
        tbl[8]  = '{1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h12, 3'd0, 2'b00, 32'd2, 32'd2};
        tbl[9]  = '{1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h22, 3'd1, 2'b00, 32'd3, 32'd2};
        tbl[10] = '{1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 2'b00, 32'd3, 32'd3};

        rst_n = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 16'h0000, 1'b0);
        #1;
        chk("reset out_valid", 32'(ifc.out_valid), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset sc_ok_cnt", sc_ok_cnt, 32'd0);
        chk("reset sc_fail_cnt", sc_fail_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].do_rst) do_reset();
            drive(tbl[i].en, tbl[i].vld, tbl[i].suc, tbl[i].cid, tbl[i].rdy);
            #1;
            chk($sformatf("row%0d out_valid", i), 32'(ifc.out_valid), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                chk($sformatf("row%0d out_success", i), 32'(ifc.out_success), 32'(tbl[i].e_suc));
                chk($sformatf("row%0d out_coreid", i), 32'(ifc.out_coreid), 32'(tbl[i].e_cid));
                chk($sformatf("row%0d out_channel", i), 32'(ifc.out_channel), 32'(tbl[i].e_ch));
            end
            chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
            chk($sformatf("row%0d sc_ok_cnt", i), sc_ok_cnt, tbl[i].e_ok);
            chk($sformatf("row%0d sc_fail_cnt", i), sc_fail_cnt, tbl[i].e_fail);
            @(negedge clk);
        end

        // overflow: ch1 pushes 5 into a 4-deep FIFO while stalled
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'b10, 2'b10, {8'h31 + 8'(k), 8'h00}, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 2'b00, 2'b00, 16'h0000, 1'b0);
        #1;
        chk("ovf flag", 32'(overflow), 32'h2);
        chk("ovf head channel", 32'(ifc.out_channel), 32'd1);
        chk("ovf head coreid", 32'(ifc.out_coreid), 32'h31);
        @(negedge clk);
        drain(8);
        chk("ovf delivered count", 32'(got_q.size()), 32'd4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("ovf delivered %0d", j), 32'(got_at(j)), 32'h31 + 32'(j));
        chk("ovf ok count", sc_ok_cnt, 32'd4);

        // stall: ch0 head held while ch1 keeps pushing
        do_reset();
        drive(1'b1, 2'b01, 2'b01, 16'h0011, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'b10, 2'b00, {8'h40 + 8'(k), 8'h00}, 1'b0);
            #1;
            chk($sformatf("stall%0d out_valid", k), 32'(ifc.out_valid), 32'd1);
            chk($sformatf("stall%0d out_coreid", k), 32'(ifc.out_coreid), 32'h11);
            chk($sformatf("stall%0d out_channel", k), 32'(ifc.out_channel), 32'd0);
            @(negedge clk);
        end

        // lock: ch1 presented and stalled, then ch0 (rr_ptr target) fills
        do_reset();
        drive(1'b1, 2'b10, 2'b10, 16'h5100, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'b01, 2'b01, 16'h0052, 1'b0);
        #1;
        chk("lock0 out_channel", 32'(ifc.out_channel), 32'd1);
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 16'h0000, 1'b0);
        #1;
        chk("lock1 out_channel", 32'(ifc.out_channel), 32'd1);
        chk("lock1 out_coreid", 32'(ifc.out_coreid), 32'h51);
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 16'h0000, 1'b1);
        #1;
        chk("lock2 out_coreid", 32'(ifc.out_coreid), 32'h51);
        @(negedge clk);
        #1;
        chk("lock3 out_channel", 32'(ifc.out_channel), 32'd0);
        chk("lock3 out_coreid", 32'(ifc.out_coreid), 32'h52);
        @(negedge clk);

        // full FIFO with simultaneous push and pop
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'b01, 2'b00, {8'h00, 8'h01 + 8'(k)}, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 2'b01, 2'b00, 16'h0022, 1'b1);
        #1;
        chk("fullpp head", 32'(ifc.out_coreid), 32'h01);
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 16'h0000, 1'b0);
        #1;
        chk("fullpp overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        drain(8);
        chk("fullpp delivered count", 32'(got_q.size()), 32'd4);
        chk("fullpp d0", 32'(got_at(0)), 32'h02);
        chk("fullpp d1", 32'(got_at(1)), 32'h03);
        chk("fullpp d2", 32'(got_at(2)), 32'h04);
        chk("fullpp d3", 32'(got_at(3)), 32'h22);
        chk("fullpp fail count", sc_fail_cnt, 32'd5);

        // reset mid-run with 3 events queued
        do_reset();
        drive(1'b1, 2'b11, 2'b01, 16'h6261, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'b01, 2'b01, 16'h0063, 1'b1);
        #1;
        chk("midrst head", 32'(ifc.out_coreid), 32'h61);
        @(negedge clk);
        drive(1'b1, 2'b10, 2'b00, 16'h6400, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 16'h0000, 1'b0);
        #1;
        chk("midrst pre ok", sc_ok_cnt, 32'd1);
        chk("midrst pre valid", 32'(ifc.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(ifc.out_valid), 32'd0);
        chk("midrst sc_ok_cnt", sc_ok_cnt, 32'd0);
        chk("midrst sc_fail_cnt", sc_fail_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drain(5);
        chk("midrst stale events", 32'(got_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
